// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full_adder, one bit per clock, LSB first.
// Optional signed-overflow output `ovf` is built when SERIAL_ADD_OVF_EN is defined.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per cycle through the full adder
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             co_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_co;
  logic             accept, last_bit;

  full_adder u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .ci  (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_bit = (state_q == S_RUN) && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    if (accept) begin
      a_d     = a_in;
      b_d     = b_in;
      carry_d = ci_in;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      // New sum bit enters at the MSB so bit 0 lands in place after WIDTH shifts
      res_d   = {fa_sum, res_q[WIDTH-1:1]};
      carry_d = fa_co;
      a_d     = {1'b0, a_q[WIDTH-1:1]};
      b_d     = {1'b0, b_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CW'(1);
      if (last_bit) begin
        sum_d = {fa_sum, res_q[WIDTH-1:1]};
        co_d  = fa_co;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign sum_out = sum_q;
  assign co_out  = co_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // Carry into the MSB is the carry flop during the last bit
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) ovf_d = carry_q ^ fa_co;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

- Bit-serial adder controller: adds two WIDTH-bit operands using a single `full_adder` instance, one bit per clock, LSB first.
- Operands are latched on `start`; a carry flip-flop feeds `co` back into `ci` between bits.
- Asserts a one-cycle `done` with the held result.
- Sits between a requesting block and the shared one-bit adder datapath, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and result width in bits, legal range 2..32.
- `clk`  input  1  the single clock domain; all state updates on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  input  1  request; sampled only in IDLE or DONE.
- `a_in`  input  WIDTH  operand A; latched on an accepted `start`.
- `b_in`  input  WIDTH  operand B; latched on an accepted `start`.
- `ci_in`  input  1  initial carry-in; latched on an accepted `start`.
- `busy`  output  1  high while bits are being processed (RUN).
- `done`  output  1  one-cycle pulse, result valid.
- `sum_out`  output  WIDTH  result; held from `done` until the next accepted `start`.
- `co_out`  output  1  final carry-out; held like `sum_out`.

## Operation
- Internal `full_adder` instance:
  - `a` = LSB of A shift register.
  - `b` = LSB of B shift register.
  - `ci` = carry flip-flop.
  - `sum` and `co` are consumed every RUN cycle.
- State registers:
  - A and B shift registers, WIDTH each, shift right.
  - Result shift register, WIDTH: each new `sum` bit enters at the MSB, shifting right.
  - Carry flip-flop.
  - Bit counter, $clog2(WIDTH) bits.
  - FSM with states IDLE, RUN, DONE.
- IDLE:
  - `start`=1 latches `a_in`, `b_in` and `ci_in` into the carry flip-flop.
  - Clears the counter, enters RUN.
- RUN, every cycle:
  - Result register takes `sum`, carry flip-flop takes `co`.
  - A and B shift right by one; counter increments.
  - When counter == WIDTH-1, the current bit is the last; next state is DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `sum_out` = result register; `co_out` = carry flip-flop.
  - `start`=1 here is accepted exactly as in IDLE (back-to-back) and goes to RUN; otherwise go to IDLE.
- `start` during RUN: ignored. No queueing, no effect on the operation in flight.
- Changes on `a_in`, `b_in` or `ci_in` after acceptance: no effect.
- Arithmetic: `{co_out, sum_out}` = `a_in` + `b_in` + `ci_in`, modulo 2^(WIDTH+1), unsigned.
- Reset (`rst_n`=0 at an edge), in any state including mid-RUN:
  - FSM goes to IDLE; all registers clear.
  - `busy`=0, `done`=0, `sum_out`=0, `co_out`=0.
  - Partial results are discarded; `done` is not issued for the aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `sum_out`=0, `co_out`=0, FSM=IDLE.
- `start` accepted at edge k:
  - `busy`=1 from edge k to edge k+WIDTH (WIDTH cycles).
  - `done`=1 in the cycle after edge k+WIDTH.
  - Start-to-done latency is WIDTH cycles.
- Back-to-back throughput: one operation per WIDTH+1 cycles.
- All outputs are registered; no combinational path from any input to any output.
- `sum_out` and `co_out` update only on entry to DONE or on reset.

## Configuration
- Macro: `SERIAL_ADD_OVF_EN`.
- Defined:
  - Adds output `ovf` (1 bit): signed two's-complement overflow, i.e. carry into the MSB XOR carry out of the MSB.
  - Captured on the last RUN bit.
  - Valid and held alongside `sum_out`; reset value 0.
- Undefined: no `ovf` port and no associated logic; all other behaviour identical.

## Test plan
- WIDTH=8, reset for 3 cycles -> `busy`=0, `done`=0, `sum_out`=0x00, `co_out`=0 throughout.
- Carry chain into a higher bit: `a_in`=0x0F, `b_in`=0x01, `ci_in`=0, `start` at edge k -> `busy` for 8 cycles; `done` after edge k+8; `sum_out`=0x10, `co_out`=0.
- Full carry ripple: `a_in`=0xFF, `b_in`=0x01, `ci_in`=0 -> `sum_out`=0x00, `co_out`=1.
- Maximum sum, then back-to-back:
  - `a_in`=0xFF, `b_in`=0xFF, `ci_in`=1 -> `sum_out`=0xFF, `co_out`=1.
  - `start` held in the DONE cycle with 0x01+0x02 -> next `done` exactly 9 cycles later, `sum_out`=0x03.
- Ignored start and mid-operation reset:
  - `start` pulsed with new operands at RUN cycle 4 -> ignored; result unchanged.
  - `rst_n`=0 at RUN cycle 5 -> IDLE next cycle, no `done`, `sum_out`=0.
- With `SERIAL_ADD_OVF_EN`: 0x7F+0x01 -> `sum_out`=0x80, `ovf`=1, `co_out`=0; 0xFF+0x01 -> `ovf`=0, `co_out`=1.
